multi16_sched: RTL and testbench
================================

# multi16_sched

Round-robin scheduler that shares one combinational `multi16` twiddle multiplier (17-bit sample × 8-bit twiddle → 17-bit product) among four requesters, such as the butterfly lanes of one FFT stage. It sits between the lanes and the multiplier instance. It arbitrates per-lane valid/ready requests and registers the operands it drives into the multiplier. It returns each product through a registered, back-pressured result port tagged with the source lane.

## Interface
- `A_W`, default 17: sample operand and product width; must match `multi16`.
- `B_W`, default 8: twiddle operand width; must match `multi16`.
- The requester count is fixed at 4 and the ID is 2 bits wide.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  4  per-lane request valid.
- `req_ready`  out  4  per-lane grant; a handshake completes when valid and ready are both high at a rising edge.
- `req_a`  in  4×A_W  lane i sample is `req_a[i*A_W +: A_W]`; two's complement.
- `req_b`  in  4×B_W  lane i twiddle is `req_b[i*B_W +: B_W]`; two's complement.
- `mul_a`  out  A_W  operand to `multi16.in_17bit`, registered.
- `mul_b`  out  B_W  operand to `multi16.in_8bit`, registered.
- `mul_p`  in  A_W  product from `multi16.out`, combinational from `mul_a`/`mul_b`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumer ready.
- `out_data`  out  A_W  product, registered.
- `out_id`  out  2  lane index of `out_data`.

## Operation
- **Stage 1 (operand register).**
  - State: `v1` and `id1`, plus `mul_a`/`mul_b`.
  - On a grant, it loads the granted lane's `req_a`/`req_b` and ID, and sets `v1`.
- **Stage 2 (result register).**
  - State: `out_valid`, `out_data`, `out_id`.
  - It captures `mul_p` and `id1` when `v1` is set and `s2_free` is high.
- **Flow control.**
  - `s2_free = !out_valid || out_ready`.
  - `s1_free = !v1 || s2_free`.
- **Arbitration.**
  - A combinational grant goes to the first lane with `req_valid` high, searching from pointer `ptr` upward with wrap 3→0.
  - The grant is qualified by `s1_free`.
  - At most one bit of `req_ready` is high in any cycle.
  - `req_ready` depends on `req_valid`, so requesters must not make `req_valid` depend on `req_ready`.
- **Pointer update.**
  - After a handshake on lane i, `ptr` becomes (i+1) mod 4.
  - With no handshake, `ptr` holds.
- **Operand hold.** When stage 1 is not reloaded, `mul_a`/`mul_b` hold their value. They do not return to zero, which avoids needless multiplier toggling.
- **Clearing the stages.**
  - `v1` clears when stage 1 empties into stage 2 and there is no new grant.
  - `out_valid` clears on `out_ready` when no new result is arriving.
- **Arithmetic.** The block does none. `out_data` equals `mul_p` for the captured operands, bit for bit.
- **Reset.**
  - Asynchronous `rst` clears `ptr`, `v1`, `id1`, `mul_a`, `mul_b`, `out_valid`, `out_data` and `out_id` to 0.
  - `req_ready` is 0 while `rst` is high.
  - In-flight operations are dropped and no result is produced for them.

## Timing
- **Latency:** a handshake at edge N gives `out_valid` high after edge N+1. `out_data` is therefore visible in cycle N+2, two cycles after request acceptance.
- **Throughput:** one operation per cycle while `out_ready` stays high.
- **Back-pressure:**
  - With `out_valid` high and `out_ready` low, stage 2 holds.
  - If `v1` is also set, stage 1 holds and `req_ready` is all zero.
  - Up to two results are buffered and none is lost or duplicated.
- **Simultaneous events:** when `out_ready` is high, drain and refill happen in the same cycle, so stage 2 reloads from stage 1 and stage 1 reloads from a new grant.
- **Multiplier path:** `mul_p` must settle within one cycle, from the `mul_a`/`mul_b` register to `out_data`.

## Configuration
- **`MULTI16_SCHED_FIXED_PRIO_EN` defined:**
  - Fixed priority applies: lane 0 is highest and lane 3 is lowest.
  - `ptr` is not implemented, and the search always starts at lane 0.
- **Undefined (default):** round-robin as described under Operation.

## Test plan
- **Single op:** after reset, raise lane 2 only with `req_a=17'h01108`, `req_b=8'h7F`, and hold `out_ready=1`.
  - `req_ready=4'b0100` for one cycle.
  - `mul_a`/`mul_b` show the operands at N+1.
  - `out_valid=1` at N+2 with `out_data` equal to the `multi16` product of those operands and `out_id=2`.
- **Fairness:** hold all four lanes valid for 8 cycles with `out_ready=1`.
  - Grants go in order 0,1,2,3,0,1,2,3.
  - `out_id` follows the same sequence two cycles later.
  - With `MULTI16_SCHED_FIXED_PRIO_EN` defined, all 8 grants go to lane 0.
- **Back-pressure:** stream lanes 0 and 1 and drop `out_ready` for 3 cycles.
  - `req_ready` goes to 0 after both stages fill.
  - `out_data`/`out_id` stay stable.
  - On release, the results emerge in order with no loss or duplication.
- **Wrap:** grant lane 3, then make lanes 0 and 3 valid. The next grant is lane 0.
- **Mid-operation reset:** assert `rst` for one cycle while both stages are full.
  - All outputs go to 0 immediately, asynchronously.
  - `out_valid` stays 0 until a new request is accepted.
  - The first grant after reset goes to the lowest valid lane, with `ptr=0`.
- **Idle:** with no `req_valid`, `req_ready=0`, `out_valid=0`, and `mul_a`/`mul_b` hold their last values.

Source files
------------

// File: rtl/multi16_sched.sv
// Round-robin scheduler sharing one multi16 twiddle multiplier among four lanes.
// Define MULTI16_SCHED_FIXED_PRIO_EN for fixed priority (lane 0 highest, no pointer).
module multi16_sched #(
  parameter int A_W = 17,
  parameter int B_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [4*A_W-1:0]     req_a,
  input  logic [4*B_W-1:0]     req_b,
  output logic [A_W-1:0]       mul_a,
  output logic [B_W-1:0]       mul_b,
  input  logic [A_W-1:0]       mul_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W-1:0]       out_data,
  output logic [1:0]           out_id
);

  logic           v1_r;
  logic [1:0]     id1_r;
  logic           s2_free_s;
  logic           s1_free_s;
  logic           gnt_any_s;
  logic [1:0]     gnt_id_s;
  logic [1:0]     start_s;
  logic           hs_s;
  logic [A_W-1:0] lane_a_s [4];
  logic [B_W-1:0] lane_b_s [4];

  assign s2_free_s = !out_valid || out_ready;
  assign s1_free_s = !v1_r || s2_free_s;
  assign hs_s      = |req_ready;

`ifdef MULTI16_SCHED_FIXED_PRIO_EN
  assign start_s = 2'd0;
`else
  logic [1:0] ptr_r;
  assign start_s = ptr_r;

  // Round-robin pointer: moves just past the lane that completed a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else if (hs_s) begin
      ptr_r <= gnt_id_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Split the packed lane buses into per-lane operands.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_a_s[i] = req_a[i*A_W +: A_W];
      lane_b_s[i] = req_b[i*B_W +: B_W];
    end
  end

  // Search from the start lane upward; scanning backwards lets the nearest valid lane win.
  always_comb begin
    logic [1:0] idx_s;
    idx_s     = 2'd0;
    gnt_any_s = 1'b0;
    gnt_id_s  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx_s     = start_s + 2'(k);
      gnt_any_s = req_valid[idx_s] ? 1'b1  : gnt_any_s;
      gnt_id_s  = req_valid[idx_s] ? idx_s : gnt_id_s;
    end
  end

  // Grant is gated by stage-1 space and forced off while reset is asserted.
  always_comb begin
    req_ready = 4'b0000;
    if (gnt_any_s && s1_free_s && !rst) begin
      req_ready[gnt_id_s] = 1'b1;
    end else begin
      req_ready = 4'b0000;
    end
  end

  // Stage 1: operand register; operands hold when not reloaded to avoid multiplier toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r  <= 1'b0;
      id1_r <= 2'd0;
      mul_a <= {A_W{1'b0}};
      mul_b <= {B_W{1'b0}};
    end else if (hs_s) begin
      v1_r  <= 1'b1;
      id1_r <= gnt_id_s;
      mul_a <= lane_a_s[gnt_id_s];
      mul_b <= lane_b_s[gnt_id_s];
    end else if (s2_free_s) begin
      v1_r  <= 1'b0;
    end else begin
      v1_r  <= v1_r;
    end
  end

  // Stage 2: result register capturing the multiplier product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {A_W{1'b0}};
      out_id    <= 2'd0;
    end else if (v1_r && s2_free_s) begin
      out_valid <= 1'b1;
      out_data  <= mul_p;
      out_id    <= id1_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_multi16_sched.sv
// Randomized self-checking bench for multi16_sched with a queue-based reference model.
module tb_multi16_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_ready;
  logic [67:0] req_a = 68'd0;
  logic [31:0] req_b = 32'd0;
  logic [16:0] mul_a;
  logic [7:0]  mul_b;
  logic [16:0] mul_p;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] out_data;
  logic [1:0]  out_id;

  typedef struct {
    logic [1:0]  id;
    logic [16:0] d;
    int          e;
  } item_t;

  item_t       q[$];
  int          cyc = 0;
  int          ptr = 0;
  logic [16:0] last_a = 17'd0;
  logic [7:0]  last_b = 8'd0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the external multi16: Q1.7 twiddle product, truncated to 17 bits.
  function automatic logic [16:0] mult16(input logic [16:0] a, input logic [7:0] b);
    logic signed [24:0] p;
    p = $signed(a) * $signed(b);
    return p[23:7];
  endfunction

  assign mul_p = mult16(mul_a, mul_b);

  multi16_sched #(.A_W(17), .B_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // First valid lane at or after the model pointer, or -1 if none.
  function automatic int pick(input logic [3:0] rv);
    int start;
`ifdef MULTI16_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (rv[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [3:0] rv, input logic ordy, input bit rnd);
    int         g;
    logic       exp_ov;
    logic [3:0] exp_rdy;
    #1;
    req_valid = rv;
    out_ready = ordy;
    if (rnd) begin
      for (int i = 0; i < 4; i++) begin
        req_a[i*17 +: 17] = 17'($urandom);
        req_b[i*8 +: 8]   = 8'($urandom);
      end
    end
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].e + 1);
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check_eq("out_data", 32'(out_data), 32'(q[0].d));
      check_eq("out_id", 32'(out_id), 32'(q[0].id));
    end
    check_eq("mul_a", 32'(mul_a), 32'(last_a));
    check_eq("mul_b", 32'(mul_b), 32'(last_b));
    g = pick(rv);
    exp_rdy = (g >= 0 && (q.size() < 2 || ordy)) ? 4'(1 << g) : 4'b0000;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    cyc++;
    if (exp_ov && ordy) void'(q.pop_front());
    if (exp_rdy != 4'b0000) begin
      last_a = req_a[g*17 +: 17];
      last_b = req_b[g*8 +: 8];
      q.push_back('{id: 2'(g), d: mult16(last_a, last_b), e: cyc});
      ptr = (g + 1) % 4;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check_eq({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    check_eq({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_odata"}, 32'(out_data), 32'd0);
    check_eq({tag, "_oid"}, 32'(out_id), 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    ptr    = 0;
    last_a = 17'd0;
    last_b = 8'd0;
  endtask

  initial begin
    // Power-on reset with requests pending: grants must stay off.
    req_valid = 4'b1111;
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();

    // Single op on lane 2 with fixed operands.
    req_a[2*17 +: 17] = 17'h01108;
    req_b[2*8 +: 8]   = 8'h7F;
    cycle(4'b0100, 1'b1, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);

    // Fairness: all lanes valid for 8 cycles.
    repeat (8) cycle(4'b1111, 1'b1, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1, 1'b1);

    // Back-pressure while streaming lanes 0 and 1.
    repeat (2) cycle(4'b0011, 1'b1, 1'b1);
    repeat (3) cycle(4'b0011, 1'b0, 1'b1);
    repeat (4) cycle(4'b0011, 1'b1, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1, 1'b1);

    // Wrap: lane 3 then lanes 0 and 3.
    cycle(4'b1000, 1'b1, 1'b1);
    cycle(4'b1001, 1'b1, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1, 1'b1);

    // Random traffic.
    repeat (300) cycle(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);

    // Mid-operation reset with both stages full.
    repeat (4) cycle(4'b1111, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    repeat (2) cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0110, 1'b1, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1, 1'b1);

    // More random traffic, including idle stretches with stalled output.
    repeat (200) cycle(4'($urandom) & 4'($urandom), 1'($urandom), 1'b1);
    repeat (4) cycle(4'b0000, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
